mat_tile_loader: RTL and testbench

Upstream feeder for the N×N systolic-free matrix multiplier. Accepts a serial stream of signed W_IN-bit elements over a valid/ready handshake and assembles them into two row-major N×N operand matrices. Each complete operand pair is issued to the multiplier as a single-cycle valid pulse, with matrices held stable. Load and issue are decoupled by a one-deep hold slot, so the next tile streams in while the current one waits for issue. Every issue is tagged with accumulation-window flags.

---
 rtl/mat_tile_loader.sv | 133 +++++++++++++
 tb/tb_mat_tile_loader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mat_tile_loader.sv
// Assembles a serial element stream into row-major N x N operand pairs and issues each pair as a one-cycle pulse.
// A one-deep hold slot lets the next tile load while the current one waits for issue_en.
module mat_tile_loader #(
  parameter int W_IN    = 8,
  parameter int N       = 2,
  parameter int K_TILES = 4,
  localparam int TW     = (K_TILES > 1) ? $clog2(K_TILES) : 1
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic signed [W_IN-1:0]              s_data,
  input  logic                                issue_en,
  output logic                                valid_out,
  output logic [N-1:0][N-1:0][W_IN-1:0]       matrix_1,
  output logic [N-1:0][N-1:0][W_IN-1:0]       matrix_2,
  output logic                                acc_first,
  output logic                                acc_last,
  output logic [TW-1:0]                       tile_idx,
  output logic                                busy
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_RC  = CW'(N - 1);
  localparam logic [TW-1:0] LAST_IDX = TW'(K_TILES - 1);

  typedef logic [N-1:0][N-1:0][W_IN-1:0] mat_t;
  typedef enum logic [1:0] {LOAD_M1, LOAD_M2, FULL} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   row_q, row_d, col_q, col_d;
  mat_t            buf1_q, buf1_d, buf2_q, buf2_d;
  mat_t            m1_q, m1_d, m2_q, m2_d;
  logic            pending_q, pending_d;
  logic [TW-1:0]   tile_q, tile_d;
  logic            xfer, last_elem, slot_free, copy;

  assign s_ready   = (state_q != FULL);
  assign valid_out = pending_q && issue_en;
  assign xfer      = s_valid && s_ready;
  assign last_elem = (row_q == LAST_RC) && (col_q == LAST_RC);
  assign slot_free = !pending_q || valid_out;

  assign matrix_1  = m1_q;
  assign matrix_2  = m2_q;
  assign tile_idx  = tile_q;
  assign acc_first = valid_out && (tile_q == '0);
  assign acc_last  = valid_out && (tile_q == LAST_IDX);
  assign busy      = (state_q != LOAD_M1) || (row_q != '0) || (col_q != '0) || pending_q;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    buf1_d    = buf1_q;
    buf2_d    = buf2_q;
    m1_d      = m1_q;
    m2_d      = m2_q;
    pending_d = pending_q;
    tile_d    = tile_q;
    copy      = 1'b0;

    if (valid_out) begin
      pending_d = 1'b0;
      tile_d    = (tile_q == LAST_IDX) ? '0 : tile_q + TW'(1);
    end

    if (xfer) begin
      if (state_q == LOAD_M1) buf1_d[row_q][col_q] = s_data;
      else                    buf2_d[row_q][col_q] = s_data;
      if (col_q == LAST_RC) begin
        col_d = '0;
        row_d = (row_q == LAST_RC) ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    case (state_q)
      LOAD_M1: if (xfer && last_elem) state_d = LOAD_M2;
      LOAD_M2: begin
        if (xfer && last_elem) begin
          if (slot_free) begin
            copy    = 1'b1;
            state_d = LOAD_M1;
          end else begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (valid_out) begin
          copy    = 1'b1;
          state_d = LOAD_M1;
        end
      end
      default: state_d = LOAD_M1;
    endcase

    // buf2_d already holds the final M2 element arriving on this edge
    if (copy) begin
      m1_d      = buf1_d;
      m2_d      = buf2_d;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= LOAD_M1;
      row_q     <= '0;
      col_q     <= '0;
      buf1_q    <= '0;
      buf2_q    <= '0;
      m1_q      <= '0;
      m2_q      <= '0;
      pending_q <= 1'b0;
      tile_q    <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      buf1_q    <= buf1_d;
      buf2_q    <= buf2_d;
      m1_q      <= m1_d;
      m2_q      <= m2_d;
      pending_q <= pending_d;
      tile_q    <= tile_d;
    end
  end

endmodule

// File: tb/tb_mat_tile_loader.sv
// Directed bench for mat_tile_loader: expected tiles are queued as their last element is accepted and checked on issue.
module tb_mat_tile_loader;

  localparam int W  = 8;
  localparam int N  = 2;
  localparam int K  = 4;
  localparam int MW = N * N * W;

  typedef struct packed {
    logic [MW-1:0] m1;
    logic [MW-1:0] m2;
    logic          af;
    logic          al;
    logic [1:0]    idx;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 resetn = 1'b0;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic signed [W-1:0]  s_data = '0;
  logic                 issue_en = 1'b0;
  logic                 valid_out;
  logic [MW-1:0]        matrix_1, matrix_2;
  logic                 acc_first, acc_last;
  logic [1:0]           tile_idx;
  logic                 busy;

  mat_tile_loader #(.W_IN(W), .N(N), .K_TILES(K)) dut (
    .clk(clk), .resetn(resetn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .issue_en(issue_en), .valid_out(valid_out),
    .matrix_1(matrix_1), .matrix_2(matrix_2),
    .acc_first(acc_first), .acc_last(acc_last),
    .tile_idx(tile_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int hs = 0;
  int cnt = 0;
  int pushes = 0;
  int n_issue = 0;
  exp_t sb[$];
  logic [2*MW-1:0] cur = '0;
  logic [15:0] firsts = '0, lasts = '0;
  logic vo_s, rdy_s, busy_s, af_s, al_s;
  logic [1:0] tidx_s;
  logic [MW-1:0] m1_s, m2_s;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, sample at negedge, score any issue, update the model, then advance.
  task automatic step(input logic v, input logic [W-1:0] d, input logic ien, input logic rn);
    exp_t e;
    s_valid = v; s_data = d; issue_en = ien; resetn = rn;
    @(negedge clk);
    vo_s = valid_out; rdy_s = s_ready; busy_s = busy; tidx_s = tile_idx;
    m1_s = matrix_1; m2_s = matrix_2; af_s = acc_first; al_s = acc_last;
    if (valid_out) begin
      n_issue++;
      firsts = {firsts[14:0], acc_first};
      lasts  = {lasts[14:0], acc_last};
      if (sb.size() == 0) begin
        chk("unexpected_issue", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_m1", 64'(matrix_1), 64'(e.m1));
        chk("sb_m2", 64'(matrix_2), 64'(e.m2));
        chk("sb_acc_first", 64'(acc_first), 64'(e.af));
        chk("sb_acc_last", 64'(acc_last), 64'(e.al));
        chk("sb_tile_idx", 64'(tile_idx), 64'(e.idx));
      end
    end
    if (!rn) begin
      cnt = 0; pushes = 0; sb.delete();
    end else if (v && s_ready) begin
      hs++;
      cur[cnt*W +: W] = d;
      cnt++;
      if (cnt == 2*N*N) begin
        e.m1  = cur[MW-1:0];
        e.m2  = cur[2*MW-1:MW];
        e.af  = (pushes % K) == 0;
        e.al  = (pushes % K) == K - 1;
        e.idx = 2'(pushes % K);
        sb.push_back(e);
        pushes++;
        cnt = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int h0;
    logic [W-1:0] sv[8];

    step(0, 8'd0, 0, 0);
    step(0, 8'd0, 0, 0);
    step(0, 8'd0, 0, 1);
    chk("rst_s_ready", 64'(rdy_s), 64'd1);
    chk("rst_valid_out", 64'(vo_s), 64'd0);
    chk("rst_busy", 64'(busy_s), 64'd0);
    chk("rst_tile_idx", 64'(tidx_s), 64'd0);
    chk("rst_acc", 64'({af_s, al_s}), 64'd0);
    chk("rst_mats", 64'({m1_s, m2_s}), 64'd0);

    // basic tile 1..8, issue_en high
    for (int i = 1; i <= 8; i++) step(1, W'(i), 1, 1);
    chk("t1_no_early_issue", 64'(n_issue), 64'd0);
    step(0, 8'd0, 1, 1);
    chk("t1_issue_next_cycle", 64'(vo_s), 64'd1);
    step(0, 8'd0, 1, 1);
    chk("t1_single_pulse", 64'(vo_s), 64'd0);
    chk("t1_tile_idx", 64'(tidx_s), 64'd1);
    chk("t1_busy", 64'(busy_s), 64'd0);
    chk("t1_m1", 64'(m1_s), 64'h04030201);
    chk("t1_m2", 64'(m2_s), 64'h08070605);

    // signed passthrough
    sv = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'h01, 8'hFE, 8'h03, 8'hFC};
    for (int i = 0; i < 8; i++) step(1, sv[i], 1, 1);
    step(0, 8'd0, 1, 1);
    step(0, 8'd0, 1, 1);
    chk("sgn_m1", 64'(m1_s), 64'h00FF7F80);
    chk("sgn_m2", 64'(m2_s), 64'hFC03FE01);

    // backpressure: two tiles with issue_en low
    h0 = hs;
    for (int i = 0; i < 16; i++) step(1, W'(30 + i), 0, 1);
    chk("bp_accepted", 64'(hs - h0), 64'd16);
    step(0, 8'd0, 0, 1);
    chk("bp_full_ready", 64'(rdy_s), 64'd0);
    chk("bp_held_vo", 64'(vo_s), 64'd0);
    chk("bp_busy", 64'(busy_s), 64'd1);
    chk("bp_hold_tile1", 64'(m1_s), 64'h21201F1E);
    step(0, 8'd0, 1, 1);
    chk("bp_issue1", 64'(vo_s), 64'd1);
    step(0, 8'd0, 1, 1);
    chk("bp_issue2", 64'(vo_s), 64'd1);
    chk("bp_ready_after", 64'(rdy_s), 64'd1);
    step(0, 8'd0, 1, 1);
    chk("bp_done_vo", 64'(vo_s), 64'd0);
    chk("bp_idle_busy", 64'(busy_s), 64'd0);

    // fifth issue wraps the window
    for (int i = 0; i < 8; i++) step(1, W'(40 + i), 1, 1);
    step(0, 8'd0, 1, 1);
    step(0, 8'd0, 1, 1);
    chk("win_issues", 64'(n_issue), 64'd5);
    chk("win_first_flags", 64'(firsts[4:0]), 64'b10001);
    chk("win_last_flags", 64'(lasts[4:0]), 64'b00010);
    chk("win_tile_idx", 64'(tidx_s), 64'd1);

    // gapped valid; junk data offered while invalid
    h0 = hs;
    for (int c = 0; c < 40 && (hs - h0) < 8; c++) begin
      if (c % 2 == 0) step(1, W'(9 + hs - h0), 1, 1);
      else            step(0, 8'hEE, 1, 1);
    end
    chk("gap_accepted", 64'(hs - h0), 64'd8);
    step(0, 8'hEE, 1, 1);
    step(0, 8'hEE, 1, 1);
    chk("gap_m1", 64'(m1_s), 64'h0C0B0A09);
    chk("gap_m2", 64'(m2_s), 64'h100F0E0D);

    // reset in the middle of a tile
    for (int i = 0; i < 5; i++) step(1, W'(50 + i), 1, 1);
    step(0, 8'd0, 1, 1);
    chk("mid_busy", 64'(busy_s), 64'd1);
    step(0, 8'd0, 1, 0);
    step(0, 8'd0, 1, 1);
    chk("mr_s_ready", 64'(rdy_s), 64'd1);
    chk("mr_valid_out", 64'(vo_s), 64'd0);
    chk("mr_busy", 64'(busy_s), 64'd0);
    chk("mr_tile_idx", 64'(tidx_s), 64'd0);
    chk("mr_mats", 64'({m1_s, m2_s}), 64'd0);
    for (int i = 0; i < 8; i++) step(1, W'(60 + i), 1, 1);
    step(0, 8'd0, 1, 1);
    step(0, 8'd0, 1, 1);
    chk("mr_m1", 64'(m1_s), 64'h3F3E3D3C);
    chk("mr_tile_idx_after", 64'(tidx_s), 64'd1);
    chk("total_issues", 64'(n_issue), 64'd7);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
